// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory arbiter: access widths,
// controller states and the owner of the access in flight.
package mem_ctrl_pkg;

  localparam logic [1:0] WIDTH_B = 2'b00;
  localparam logic [1:0] WIDTH_H = 2'b01;
  localparam logic [1:0] WIDTH_W = 2'b10;

  localparam logic [2:0] IF_NBYTES = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_e;

  // Width code 11 is treated as a full word, same as WIDTH_W.
  function automatic logic [2:0] width_to_n(input logic [1:0] w);
    case (w)
      WIDTH_B: width_to_n = 3'd1;
      WIDTH_H: width_to_n = 3'd2;
      default: width_to_n = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_byte_seq.sv
// Byte sequencer: walks N consecutive RAM byte addresses from a base, either
// writing little-endian store bytes or assembling read bytes one cycle later.
module mem_byte_seq
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [2:0]        nbytes,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  output logic [DATA_W-1:0] rdata_nxt,
  output logic              finished
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [7:0]        dout_q, dout_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        icnt_q, icnt_d;
  logic              live_q, live_d;
  logic              samp_q, samp_d;
  logic [1:0]        rcnt_q, rcnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // live_q: a read address is on the bus this cycle; samp_q: its byte is on ram_din.
  always_comb begin
    addr_d   = addr_q;
    wr_d     = wr_q;
    dout_d   = dout_q;
    wdata_d  = wdata_q;
    n_d      = n_q;
    icnt_d   = icnt_q;
    live_d   = live_q;
    samp_d   = live_q;
    rcnt_d   = rcnt_q;
    rdata_d  = rdata_q;
    finished = 1'b0;
    if (start) begin
      addr_d  = base;
      n_d     = nbytes;
      icnt_d  = 3'd1;
      rcnt_d  = 2'd0;
      rdata_d = '0;
      samp_d  = 1'b0;
      wr_d    = we;
      live_d  = ~we;
      dout_d  = we ? wdata[7:0] : dout_q;
      wdata_d = wdata >> 8;
    end else begin
      if (wr_q || live_q) begin
        if (icnt_q == n_q) begin
          wr_d     = 1'b0;
          live_d   = 1'b0;
          finished = wr_q;
        end else begin
          addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          icnt_d = icnt_q + 3'd1;
          if (wr_q) begin
            dout_d  = wdata_q[7:0];
            wdata_d = wdata_q >> 8;
          end
        end
      end
      if (samp_q) begin
        rdata_d[{rcnt_q, 3'b000} +: 8] = ram_din;
        rcnt_d = rcnt_q + 2'd1;
        if ({1'b0, rcnt_q} == n_q - 3'd1) finished = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      wdata_q <= '0;
      n_q     <= '0;
      icnt_q  <= '0;
      live_q  <= 1'b0;
      samp_q  <= 1'b0;
      rcnt_q  <= '0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      wdata_q <= wdata_d;
      n_q     <= n_d;
      icnt_q  <= icnt_d;
      live_q  <= live_d;
      samp_q  <= samp_d;
      rcnt_q  <= rcnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wr    = wr_q;
  assign ram_dout  = dout_q;
  assign rdata_nxt = rdata_d;

endmodule

// File: rtl/mem_ctrl.sv
// Single-port arbiter between instruction fetch and load/store over a
// byte-wide synchronous RAM; MEM wins ties and both sides stall until done.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_width,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic              stallreq_if,
  output logic              stallreq_mem
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;

  logic              seq_start;
  logic [ADDR_W-1:0] seq_base;
  logic [2:0]        seq_n;
  logic              seq_we;
  logic [DATA_W-1:0] seq_rdata;
  logic              seq_fin;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    seq_start   = 1'b0;
    seq_base    = mem_addr;
    seq_n       = width_to_n(mem_width);
    seq_we      = mem_we;
    case (state_q)
      ST_IDLE: begin
        if (mem_req) begin
          seq_start = 1'b1;
          owner_d   = OWN_MEM;
          state_d   = mem_we ? ST_WRITE : ST_READ;
        end else if (if_req) begin
          seq_start = 1'b1;
          seq_base  = if_addr;
          seq_n     = IF_NBYTES;
          seq_we    = 1'b0;
          owner_d   = OWN_IF;
          state_d   = ST_READ;
        end
      end
      ST_READ, ST_WRITE: begin
        // Completion is registered so done and data appear together next cycle.
        if (seq_fin) begin
          state_d = ST_DONE;
          if (owner_q == OWN_MEM) begin
            mem_done_d = 1'b1;
            if (state_q == ST_READ) mem_rdata_d = seq_rdata;
          end else begin
            if_done_d = 1'b1;
            if_data_d = seq_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  mem_byte_seq #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (seq_start),
    .base     (seq_base),
    .nbytes   (seq_n),
    .we       (seq_we),
    .wdata    (mem_wdata),
    .ram_din  (ram_din),
    .ram_addr (ram_addr),
    .ram_wr   (ram_wr),
    .ram_dout (ram_dout),
    .rdata_nxt(seq_rdata),
    .finished (seq_fin)
  );

  assign if_data      = if_data_q;
  assign mem_rdata    = mem_rdata_q;
  assign if_done      = if_done_q;
  assign mem_done     = mem_done_q;
  assign stallreq_if  = if_req & ~if_done_q;
  assign stallreq_mem = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model plus a reference memory image that
// predicts addresses, strobes, completion cycles and assembled data.
module tb_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_width;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic        stallreq_if;
  logic        stallreq_mem;

  int total = 0;
  int bad = 0;

  logic [7:0]  ram  [logic [31:0]];
  logic [7:0]  gold [logic [31:0]];
  logic [31:0] last_if = 32'h0;
  logic [31:0] last_mem = 32'h0;
  bit          mem_hold_ok = 1'b1;

  mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_data     (if_data),
    .if_done     (if_done),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_width   (mem_width),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_done    (mem_done),
    .ram_din     (ram_din),
    .ram_dout    (ram_dout),
    .ram_addr    (ram_addr),
    .ram_wr      (ram_wr),
    .stallreq_if (stallreq_if),
    .stallreq_mem(stallreq_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_byte(a);
  endfunction

  // Synchronous byte RAM: read data appears one cycle after its address.
  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr] = ram_dout;
    ram_din <= ram_rd(ram_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]  = b;
    gold[a] = b;
  endtask

  // One access from acceptance (j=0) through its done cycle. 'both' raises
  // if_req together with mem_req; drop_at withdraws if_req and raises a
  // pending mem_req at that cycle of an IF access.
  task automatic txn(input bit is_mem, input bit we, input logic [1:0] w,
                     input logic [31:0] a, input logic [31:0] wd,
                     input bit both, input int drop_at);
    int n;
    int dcyc;
    logic [31:0] exp_data;
    logic [31:0] exp_a;
    logic exp_ifd;
    logic exp_memd;
    bit is_store;
    is_store = is_mem && we;
    n = !is_mem ? 4 : (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
    dcyc = is_store ? n + 1 : n + 2;
    exp_data = 32'h0;
    if (!is_store)
      for (int k = 0; k < n; k++) exp_data[8*k +: 8] = gold_rd(a + k);
    for (int j = 0; j <= dcyc; j++) begin
      @(negedge clk);
      if (j == 0) begin
        if (is_mem) begin
          mem_req = 1'b1; mem_we = we; mem_width = w; mem_addr = a; mem_wdata = wd;
          if (both) if_req = 1'b1;
        end else begin
          if_req = 1'b1; if_addr = a;
        end
      end
      if (drop_at != 0 && j == drop_at) begin
        if_req = 1'b0;
        mem_req = 1'b1;
      end
      #1;
      if (j == 0) begin
        chk("if_data_hold", if_data, last_if);
        if (mem_hold_ok) chk("mem_rdata_hold", mem_rdata, last_mem);
      end
      if (j >= 1 && j <= n) begin
        exp_a = a + (j - 1);
        chk("ram_addr", ram_addr, exp_a);
        chk("ram_wr", ram_wr, is_store);
        if (is_store) chk("ram_dout", ram_dout, wd[8*(j-1) +: 8]);
      end else begin
        chk("ram_wr_off", ram_wr, 1'b0);
      end
      exp_ifd  = !is_mem && (j == dcyc);
      exp_memd = is_mem && (j == dcyc);
      chk("if_done", if_done, exp_ifd);
      chk("mem_done", mem_done, exp_memd);
      chk("stall_if", stallreq_if, if_req & ~exp_ifd);
      chk("stall_mem", stallreq_mem, mem_req & ~exp_memd);
      if (j == dcyc) begin
        if (!is_mem) begin
          chk("if_data", if_data, exp_data);
          last_if = exp_data;
          if_req = 1'b0;
        end else if (!we) begin
          chk("mem_rdata", mem_rdata, exp_data);
          last_mem = exp_data;
          mem_hold_ok = 1'b1;
          mem_req = 1'b0;
        end else begin
          for (int k = 0; k < n; k++) begin
            chk("ram_image", ram_rd(a + k), wd[8*k +: 8]);
            gold[a + k] = wd[8*k +: 8];
          end
          mem_hold_ok = 1'b0;
          mem_req = 1'b0;
        end
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_data"}, if_data, 32'h0);
    chk({tag, "_mem_rdata"}, mem_rdata, 32'h0);
    chk({tag, "_ram_addr"}, ram_addr, 32'h0);
    chk({tag, "_ram_dout"}, ram_dout, 32'h0);
    chk({tag, "_ram_wr"}, ram_wr, 1'b0);
    chk({tag, "_if_done"}, if_done, 1'b0);
    chk({tag, "_mem_done"}, mem_done, 1'b0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] prev_a;
    logic [7:0]  before_b1;
    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_width = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h10); preload(32'h103, 8'h00);
    preload(32'h10, 8'h8F);

    repeat (3) @(negedge clk);
    #1 chk_reset_outputs("por");
    rst_n = 1'b1;

    // Word fetch 0x100 -> 0x00100513, done six cycles after acceptance.
    txn(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 0);
    // Halfword store 0xDEADBEEF at 0x2000.
    txn(1'b1, 1'b1, 2'b01, 32'h2000, 32'hDEADBEEF, 1'b0, 0);
    // Simultaneous requests: MEM byte load first, then the stalled fetch.
    txn(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b1, 0);
    txn(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 0);
    // Word load wrapping past the top of the address space.
    preload(32'hFFFFFFFE, 8'h44); preload(32'hFFFFFFFF, 8'h33);
    preload(32'h0, 8'h22); preload(32'h1, 8'h11);
    txn(1'b1, 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0, 1'b0, 0);
    // Fetch whose requester drops at c2 while a byte load becomes pending.
    mem_we = 1'b0; mem_width = 2'b00; mem_addr = 32'h10;
    txn(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 2);
    txn(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0, 0);
    // Width code 11 as a word store, read back as a word.
    txn(1'b1, 1'b1, 2'b11, 32'h4000, 32'hCAFEF00D, 1'b0, 0);
    txn(1'b1, 1'b0, 2'b11, 32'h4000, 32'h0, 1'b0, 0);

    // Reset in the middle of a word store.
    before_b1 = ram_rd(32'h3001);
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b10; mem_addr = 32'h3000; mem_wdata = 32'h11223344;
    @(negedge clk);
    @(negedge clk);
    #1 chk("pre_abort_wr", ram_wr, 1'b1);
    rst_n = 1'b0;
    #1 chk_reset_outputs("abort");
    mem_req = 1'b0;
    chk("partial_b0", ram_rd(32'h3000), 8'h44);
    chk("partial_b1", ram_rd(32'h3001), before_b1);
    gold[32'h3000] = 8'h44;
    last_if = 32'h0; last_mem = 32'h0; mem_hold_ok = 1'b1;
    @(negedge clk);
    #1 chk_reset_outputs("abort_hold");
    rst_n = 1'b1;
    txn(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 1'b0, 0);

    // Random mix of fetches, loads and stores, some near the wrap point.
    prev_a = 32'h3000;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 32'hFFFFFFFC + $urandom_range(0, 3);
        1: ra = prev_a;
        default: ra = $urandom;
      endcase
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          ra, $urandom, 1'b0, 0);
      prev_a = ra;
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port memory arbiter between the IF stage (instruction fetch) and the MEM stage (load/store) and a byte-wide synchronous RAM.
- Sits directly upstream of the stall controller. It produces stallreq_if and stallreq_mem, which hold the pipeline while a multi-cycle byte-serial access is in flight.
- MEM accesses take priority over IF accesses.

Parameters:
- ADDR_W, 32, address width of requests and RAM port
- DATA_W, 32, request data width (4 bytes, little-endian)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- if_req  in  1  IF fetch request, held until if_done
- if_addr  in  ADDR_W  fetch byte address
- if_data  out  DATA_W  fetched instruction
- if_done  out  1  one-cycle completion pulse for IF
- mem_req  in  1  MEM access request, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_width  in  2  00 = byte, 01 = half, 10 or 11 = word
- mem_addr  in  ADDR_W  access byte address
- mem_wdata  in  DATA_W  store data; low bytes are used first
- mem_rdata  out  DATA_W  load data, zero-extended
- mem_done  out  1  one-cycle completion pulse for MEM
- ram_din  in  8  RAM read byte, valid one cycle after its address
- ram_dout  out  8  RAM write byte
- ram_addr  out  ADDR_W  RAM byte address
- ram_wr  out  1  RAM write enable
- stallreq_if  out  1  if_req & ~if_done (combinational)
- stallreq_mem  out  1  mem_req & ~mem_done (combinational)

Behaviour:
- Clock and reset
  - One clock.
  - Reset is asynchronous and active-low (rst_n).
  - On reset, every output register goes to 0: if_data, mem_rdata, ram_addr, ram_dout, ram_wr, if_done, mem_done. State goes to IDLE and the byte counter goes to 0.
- States: IDLE, READ, WRITE, DONE.
- IDLE
  - ram_wr = 0.
  - If mem_req: latch addr, width and wdata, set the owner to MEM, go to WRITE if mem_we else READ.
  - Else if if_req: latch if_addr, set the owner to IF, width = 4, go to READ.
  - Else stay in IDLE.
- Byte count N: 1, 2 or 4 from width. IF is always 4.
- Timing, with c0 = the IDLE cycle in which the request is accepted:
  - READ: ram_addr = base+k during cycle c0+1+k, for k = 0..N-1. Byte k is sampled from ram_din at the end of cycle c0+2+k into result bits [8k+7:8k]. Unfetched bytes are 0.
  - WRITE: ram_wr = 1, ram_addr = base+k and ram_dout = wdata[8k+7:8k] during cycle c0+1+k. ram_wr = 0 from cycle c0+N+1.
  - DONE: the owner's done signal is high for exactly one cycle, in cycle c0+N+2 for reads and c0+N+1 for writes. The owner's data output (if_data or mem_rdata) is valid in that cycle and is held until that owner's next completion. The next state is IDLE.
- Latency
  - Word fetch: request to done = 6 cycles.
  - Byte store: request to done = 2 cycles.
- Stalls
  - stallreq_* drop in the done cycle. The pipeline advances on that edge.
  - A request seen in IDLE on the following cycle is treated as a new request, with no back-to-back blocking.
- Simultaneous if_req and mem_req in IDLE: MEM is served first and IF stays stalled. IF is accepted in the IDLE cycle after the MEM DONE, unless a new mem_req is present.
- A requester dropping its req mid-operation: the operation still completes and done still pulses. Writes are never truncated.
- Address arithmetic is modulo 2^ADDR_W. base+k wraps with no error.
- Width 11 behaves exactly like 10.
- ram_addr is held at its last value outside accesses. ram_wr is never high outside WRITE.
- Asserting rst_n low mid-operation aborts immediately. Outputs take their reset values, ram_wr falls asynchronously, no done pulse is issued, and partial RAM writes remain.

Decomposition:
- Shared package / defines:
  - width encodings (WIDTH_B / WIDTH_H / WIDTH_W)
  - state encoding
  - owner encoding (OWN_IF / OWN_MEM)
- One natural sub-module, mem_byte_seq: a byte sequencer that takes a base address, N and we. It drives ram_addr, ram_wr and ram_dout, assembles the read bytes, and emits a finished pulse.
- The top level holds arbitration, owner tracking, output registers and stall generation.

Test Plan:
- Reset with rst_n = 0 mid-WRITE, then release → all outputs 0, state IDLE, ram_wr = 0 immediately; the next if_req works normally.
- if_req with if_addr = 0x100, RAM bytes {0x13, 0x05, 0x10, 0x00} → ram_addr 0x100..0x103 in c1..c4; if_done only in c6; if_data = 0x00100513; stallreq_if high c0..c5.
- mem_req store, width = 01, addr 0x2000, wdata = 0xDEADBEEF → ram_wr high in c1..c2 with 0xEF@0x2000 and 0xBE@0x2001; mem_done in c3; no write in c3.
- if_req and mem_req load byte at 0x10 (=0x8F) asserted together → MEM served first; mem_rdata = 0x0000008F in c3; IF accepted c4; if_done in c10.
- Load word at addr 0xFFFFFFFE → ram_addr sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; bytes assembled little-endian.
- if_req dropped at c2 of a fetch → fetch completes; if_done pulses at c6; the next IDLE accepts a pending mem_req.
